// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime baud divisor, majority-vote sampling, parity/stop checking,
// break detection and a show-ahead FIFO that keeps per-entry frame/parity error tags.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                          overrun,
    output logic                          break_det,
    input  logic                          err_clr,
    output logic                          rx_busy
);
    localparam int M   = OVERSAMPLE / 2;
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int BIW = $clog2(DATA_BITS);
    localparam int EW  = DATA_BITS + 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_reg, state_next;
    logic                   rx_meta, rx_s;
    logic [DIV_WIDTH-1:0]   div_reg, tick_cnt_reg;
    logic                   tick;
    logic [SCW-1:0]         sc_reg, sc_next;
    logic [BIW-1:0]         bit_idx_reg, bit_idx_next;
    logic                   stop_idx_reg, stop_idx_next;
    logic [1:0]             samp_reg, samp_next;
    logic                   vote_reg, vote_next, vote_now;
    logic [DATA_BITS-1:0]   data_reg, data_next;
    logic                   par_err_reg, par_err_next;
    logic                   frm_err_reg, frm_err_next;
    logic                   line_high_reg, line_high_next;
    logic                   decide, bit_end, commit, brk, push_req;
    logic [EW-1:0]          entry, head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // The divisor is latched only between frames so a mid-frame change cannot skew bit timing.
    assign tick = (tick_cnt_reg >= div_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg      <= '0;
            tick_cnt_reg <= '0;
        end else begin
            if (state_reg == S_IDLE)
                div_reg <= baud_div;
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + DIV_WIDTH'(1);
        end
    end

    assign decide   = tick && (sc_reg == SCW'(M + 1));
    assign bit_end  = tick && (sc_reg == SCW'(OVERSAMPLE - 1));
    assign vote_now = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            sc_reg        <= '0;
            bit_idx_reg   <= '0;
            stop_idx_reg  <= 1'b0;
            samp_reg      <= '0;
            vote_reg      <= 1'b0;
            data_reg      <= '0;
            par_err_reg   <= 1'b0;
            frm_err_reg   <= 1'b0;
            line_high_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sc_reg        <= sc_next;
            bit_idx_reg   <= bit_idx_next;
            stop_idx_reg  <= stop_idx_next;
            samp_reg      <= samp_next;
            vote_reg      <= vote_next;
            data_reg      <= data_next;
            par_err_reg   <= par_err_next;
            frm_err_reg   <= frm_err_next;
            line_high_reg <= line_high_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sc_next        = sc_reg;
        bit_idx_next   = bit_idx_reg;
        stop_idx_next  = stop_idx_reg;
        samp_next      = samp_reg;
        vote_next      = vote_reg;
        data_next      = data_reg;
        par_err_next   = par_err_reg;
        frm_err_next   = frm_err_reg;
        line_high_next = line_high_reg;
        commit         = 1'b0;

        if (tick && state_reg != S_IDLE) begin
            sc_next = (sc_reg == SCW'(OVERSAMPLE - 1)) ? '0 : sc_reg + SCW'(1);
            if (sc_reg == SCW'(M - 1)) samp_next[0] = rx_s;
            if (sc_reg == SCW'(M))     samp_next[1] = rx_s;
            if (sc_reg == SCW'(M + 1)) vote_next    = vote_now;
        end

        case (state_reg)
            S_IDLE: begin
                if (tick && !rx_s) begin
                    state_next     = S_START;
                    sc_next        = SCW'(1);
                    bit_idx_next   = '0;
                    stop_idx_next  = 1'b0;
                    data_next      = '0;
                    par_err_next   = 1'b0;
                    frm_err_next   = 1'b0;
                    line_high_next = 1'b0;
                end
            end
            S_START: begin
                if (decide && vote_now)
                    state_next = S_IDLE;
                else if (bit_end)
                    state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    data_next[bit_idx_reg] = vote_reg;
                    if (bit_idx_reg == BIW'(DATA_BITS - 1))
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    else
                        bit_idx_next = bit_idx_reg + BIW'(1);
                end
            end
            S_PARITY: begin
                if (decide) begin
                    par_err_next   = (^data_reg) ^ vote_now ^ (PARITY == 2);
                    line_high_next = line_high_reg | vote_now;
                end
                if (bit_end)
                    state_next = S_STOP;
            end
            S_STOP: begin
                if (decide) begin
                    if (vote_now)
                        line_high_next = 1'b1;
                    else
                        frm_err_next = 1'b1;
                    // Leave on the decision tick so the next start edge is not missed.
                    if (stop_idx_reg == 1'(STOP_BITS - 1)) begin
                        state_next = S_IDLE;
                        commit     = 1'b1;
                    end
                end else if (bit_end) begin
                    stop_idx_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign brk      = (data_reg == '0) && !line_high_reg && !vote_now;
    assign push_req = commit && !brk;
    assign entry    = {par_err_reg, frm_err_reg | !vote_now, data_reg};

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          full, empty, do_pop, do_push, ovr_set;

    assign full    = (count_reg == CW'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = rd_en && !empty;
    assign do_push = push_req && (!full || do_pop);
    assign ovr_set = push_req && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            overrun   <= ovr_set ? 1'b1 : (err_clr ? 1'b0 : overrun);
            break_det <= (commit && brk) ? 1'b1 : (err_clr ? 1'b0 : break_det);
        end
    end

    assign head          = empty ? '0 : mem[rd_ptr_reg];
    assign rd_data       = head[DATA_BITS-1:0];
    assign rd_frame_err  = head[DATA_BITS];
    assign rd_parity_err = head[DATA_BITS+1];
    assign rd_valid      = !empty;
    assign fifo_count    = count_reg;
    assign rx_busy       = (state_reg != S_IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: an 8N1 depth-4 receiver (line a) and an 8E1 depth-4 receiver (line b).
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int BIT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_a, rx_b, rd_en_a, rd_en_b, err_clr;
    logic [15:0] baud_div;
    logic [7:0]  a_data, b_data;
    logic        a_ferr, a_perr, a_valid, a_ovr, a_brk, a_busy;
    logic        b_ferr, b_perr, b_valid, b_ovr, b_brk, b_busy;
    logic [2:0]  a_count, b_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    int lat;
    int saw_busy;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16),
                   .FIFO_DEPTH(4), .DIV_WIDTH(16)) u_dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .baud_div(baud_div), .rd_en(rd_en_a),
        .rd_data(a_data), .rd_frame_err(a_ferr), .rd_parity_err(a_perr),
        .rd_valid(a_valid), .fifo_count(a_count), .overrun(a_ovr),
        .break_det(a_brk), .err_clr(err_clr), .rx_busy(a_busy));

    uart_rx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16),
                   .FIFO_DEPTH(4), .DIV_WIDTH(16)) u_dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .baud_div(baud_div), .rd_en(rd_en_b),
        .rd_data(b_data), .rd_frame_err(b_ferr), .rd_parity_err(b_perr),
        .rd_valid(b_valid), .fifo_count(b_count), .overrun(b_ovr),
        .break_det(b_brk), .err_clr(err_clr), .rx_busy(b_busy));

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start frames on a fixed phase of the free-running tick so latency is repeatable.
    task automatic align();
        while (cyc % 4 != 0) @(negedge clk);
    endtask

    task automatic send(input int line, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (line == 0) rx_a = bits[i];
            else           rx_b = bits[i];
            wait_clk(BIT);
        end
        $display("tx line %0d frame 0x%0h (%0d bits)", line, bits, n);
    endtask

    task automatic pop_a();
        rd_en_a = 1'b1; wait_clk(1); rd_en_a = 1'b0;
    endtask

    task automatic pop_b();
        rd_en_b = 1'b1; wait_clk(1); rd_en_b = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1; wait_clk(1); err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; wait_clk(3); rst = 1'b0; wait_clk(8);
    endtask

    task automatic check_reset_a(input string pfx);
        check({pfx, "_valid"}, a_valid, 0);
        check({pfx, "_data"},  a_data,  0);
        check({pfx, "_ferr"},  a_ferr,  0);
        check({pfx, "_perr"},  a_perr,  0);
        check({pfx, "_count"}, a_count, 0);
        check({pfx, "_ovr"},   a_ovr,   0);
        check({pfx, "_brk"},   a_brk,   0);
        check({pfx, "_busy"},  a_busy,  0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rd_en_a = 1'b0; rd_en_b = 1'b0;
        err_clr = 1'b0; baud_div = 16'd3;
        wait_clk(3);
        check_reset_a("rst0");
        rst = 1'b0;
        wait_clk(8);

        // 8N1 0xA5 with start-to-rd_valid latency
        align();
        fork
            send(0, {1'b1, 8'hA5, 1'b0}, 10);
            begin
                lat = 0;
                while (!a_valid && lat < 1000) begin wait_clk(1); lat++; end
            end
        join
        check("a5_latency_in_window", (lat >= 600 && lat <= 624), 1);
        check("a5_data", a_data, 8'hA5);
        check("a5_ferr", a_ferr, 0);
        check("a5_perr", a_perr, 0);
        check("a5_count", a_count, 1);
        pop_a();
        check("a5_pop_valid", a_valid, 0);
        check("a5_pop_data", a_data, 0);

        // even parity: 0x03 with parity 1 is wrong, 0x07 with parity 1 is right
        send(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
        send(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
        wait_clk(BIT);
        check("par_count", b_count, 2);
        check("par03_data", b_data, 8'h03);
        check("par03_perr", b_perr, 1);
        check("par03_ferr", b_ferr, 0);
        pop_b();
        check("par07_data", b_data, 8'h07);
        check("par07_perr", b_perr, 0);
        pop_b();
        check("par_empty", b_valid, 0);

        // bad stop bit
        send(0, {1'b0, 8'h55, 1'b0}, 10);
        rx_a = 1'b1;
        wait_clk(3 * BIT);
        check("fe_data", a_data, 8'h55);
        check("fe_ferr", a_ferr, 1);
        check("fe_count", a_count, 1);
        check("fe_brk", a_brk, 0);
        pop_a();

        // break: line low for 12 bit-times
        align();
        rx_a = 1'b0;
        wait_clk(12 * BIT);
        check("brk_set", a_brk, 1);
        check("brk_count", a_count, 0);
        pulse_clr();
        check("brk_clr", a_brk, 0);
        rx_a = 1'b1;
        wait_clk(14 * BIT);
        do_reset();

        // overrun on a depth-4 FIFO
        align();
        for (int d = 1; d <= 5; d++) send(0, {1'b1, 8'(d), 1'b0}, 10);
        wait_clk(BIT);
        check("ovr_count", a_count, 4);
        check("ovr_flag", a_ovr, 1);
        for (int d = 1; d <= 4; d++) begin
            check($sformatf("ovr_rd%0d", d), a_data, d);
            pop_a();
        end
        check("ovr_drained", a_valid, 0);
        pulse_clr();
        check("ovr_clr", a_ovr, 0);

        // pop exactly on the commit edge of a 5th byte into a full FIFO
        align();
        for (int d = 1; d <= 4; d++) send(0, {1'b1, 8'(d), 1'b0}, 10);
        align();
        fork
            send(0, {1'b1, 8'h05, 1'b0}, 10);
            begin
                wait_clk(lat - 1);
                rd_en_a = 1'b1; wait_clk(1); rd_en_a = 1'b0;
            end
        join
        wait_clk(BIT);
        check("pp_ovr", a_ovr, 0);
        check("pp_count", a_count, 4);
        for (int d = 2; d <= 5; d++) begin
            check($sformatf("pp_rd%0d", d), a_data, d);
            pop_a();
        end
        check("pp_drained", a_count, 0);

        // one-tick low glitch while idle
        align();
        saw_busy = 0;
        rx_a = 1'b0; wait_clk(4); rx_a = 1'b1;
        for (int i = 0; i < 60; i++) begin
            wait_clk(1);
            if (a_busy) saw_busy = 1;
        end
        check("glitch_idle_seen", saw_busy, 1);
        check("glitch_idle_busy", a_busy, 0);
        check("glitch_idle_count", a_count, 0);

        // one-tick glitch mid data bit 3 of 0xFF
        align();
        rx_a = 1'b0; wait_clk(BIT);
        rx_a = 1'b1; wait_clk(3 * BIT + BIT / 2);
        rx_a = 1'b0; wait_clk(4);
        rx_a = 1'b1; wait_clk(BIT / 2 - 4 + 5 * BIT);
        $display("tx line 0 frame 0xff with mid-bit glitch");
        wait_clk(BIT);
        check("glitch_ff_count", a_count, 1);
        check("glitch_ff_data", a_data, 8'hFF);
        check("glitch_ff_ferr", a_ferr, 0);

        // reset in the middle of a 0x3C data bit
        align();
        send(0, {1'b1, 8'h3C, 1'b0}, 4);
        wait_clk(BIT / 2);
        rst = 1'b1; rx_a = 1'b1;
        wait_clk(2);
        check_reset_a("rst1");
        rst = 1'b0;
        wait_clk(2 * BIT);
        align();
        send(0, {1'b1, 8'h81, 1'b0}, 10);
        wait_clk(BIT);
        check("post_rst_count", a_count, 1);
        check("post_rst_data", a_data, 8'h81);
        pop_a();
        check("post_rst_empty", a_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
